// File: rtl/aq_cjpeg_pkg.sv
// Shared JPEG encoder constants: bank count, level shift, block color codes
// and MCU component codes, plus the pixel level-shift helper.
package aq_cjpeg_pkg;

    localparam int         NUM_BANKS   = 4;
    localparam int         BANK_W      = 2;
    localparam logic [8:0] LEVEL_SHIFT = 9'd128;

    typedef enum logic [2:0] {
        Y0 = 3'd0,
        Y1 = 3'd1,
        Y2 = 3'd2,
        Y3 = 3'd3,
        CB = 3'd4,
        CR = 3'd5
    } color_e;

    typedef enum logic [2:0] {
        GRAY   = 3'd1,
        YCC420 = 3'd3
    } comp_e;

    function automatic logic [8:0] levelShift(input logic [7:0] pix);
        return {1'b0, pix} - LEVEL_SHIFT;
    endfunction

endpackage

// File: rtl/aq_cjpeg_ycbcr_mem_if.sv
// Pixel-in / block-out bus of the YCbCr MCU buffer; master is the
// producer/consumer side, slave is the buffer itself.
interface aq_cjpeg_ycbcr_mem_if;

    logic       DataInit;
    logic [2:0] JpegComp;
    logic       DataInEnable;
    logic [7:0] DataInAddress;
    logic [7:0] DataInY;
    logic [7:0] DataInCb;
    logic [7:0] DataInCr;
    logic       DataInFull;
    logic       DataOutEnable;
    logic       DataOutRead;
    logic [2:0] DataOutColor;
    logic [5:0] DataOutAddress;
    logic [8:0] DataOut;

    modport master (
        output DataInit, JpegComp, DataInEnable, DataInAddress,
               DataInY, DataInCb, DataInCr,
               DataOutRead, DataOutColor, DataOutAddress,
        input  DataInFull, DataOutEnable, DataOut
    );

    modport slave (
        input  DataInit, JpegComp, DataInEnable, DataInAddress,
               DataInY, DataInCb, DataInCr,
               DataOutRead, DataOutColor, DataOutAddress,
        output DataInFull, DataOutEnable, DataOut
    );

endinterface

// File: rtl/aq_cjpeg_chroma_dec.sv
// 2x2 chroma decimator for raster-ordered 16x16 MCU pixels.
// AQ_CJPEG_CHROMA_AVG_EN selects rounded 2x2 averaging instead of even/even pick.
module aq_cjpeg_chroma_dec
    import aq_cjpeg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       en,
    input  logic [7:0] pixel,
    input  logic [3:0] col,
    input  logic [3:0] row,
    output logic       we,
    output logic [5:0] addr,
    output logic [8:0] value
);

    assign addr = {row[3:1], col[3:1]};

`ifdef AQ_CJPEG_CHROMA_AVG_EN
    logic [8:0] pairSum_r;
    logic [9:0] partial_r [8];
    logic [8:0] pairSum_s;
    logic [9:0] quadSum_s;
    logic [9:0] rounded_s;

    // Completes the horizontal pair and the 2x2 quad from the stored sums
    always_comb begin
        pairSum_s = pairSum_r + {1'b0, pixel};
        quadSum_s = partial_r[col[3:1]] + {1'b0, pairSum_s};
        rounded_s = quadSum_s + 10'd2;
        if (en && row[0] && col[0]) begin
            we = 1'b1;
        end else begin
            we = 1'b0;
        end
        value = levelShift(rounded_s[9:2]);
    end

    // Running pair sum and even-row partial buffer; raster order is assumed
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            pairSum_r <= 9'd0;
            for (int i = 0; i < 8; i++) begin
                partial_r[i] <= 10'd0;
            end
        end else if (en) begin
            if (!col[0]) begin
                pairSum_r <= {1'b0, pixel};
            end else if (!row[0]) begin
                partial_r[col[3:1]] <= {1'b0, pairSum_s};
            end
        end
    end
`else
    logic unusedInputs_s;
    assign unusedInputs_s = &{1'b0, clk, rst, flush};

    // Top-left pixel of each 2x2 cell is the decimated sample
    always_comb begin
        if (en && !row[0] && !col[0]) begin
            we = 1'b1;
        end else begin
            we = 1'b0;
        end
        value = levelShift(pixel);
    end
`endif

endmodule

// File: rtl/aq_cjpeg_ycbcr_mem.sv
// Four-bank MCU buffer between the pixel producer and the DCT: stores level-shifted
// Y plus 2x2-decimated Cb/Cr; AQ_CJPEG_CHROMA_AVG_EN enables chroma averaging.
module aq_cjpeg_ycbcr_mem
    import aq_cjpeg_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    aq_cjpeg_ycbcr_mem_if.slave  bus
);

    logic [BANK_W-1:0] writeBank_r;
    logic [BANK_W-1:0] readBank_r;
    logic [1:0]        level_r;
    logic [8:0]        dataOut_r;

    logic [8:0] yMem_r  [NUM_BANKS*256];
    logic [8:0] cbMem_r [NUM_BANKS*64];
    logic [8:0] crMem_r [NUM_BANKS*64];

    logic       gray_s;
    logic       full_s;
    logic       outEnable_s;
    logic       pixEn_s;
    logic       chromaEn_s;
    logic       writeNext_s;
    logic       readNext_s;
    logic [2:0] lastColor_s;
    logic [9:0] yAddr_s;
    logic [8:0] readData_s;
    logic       cbWe_s;
    logic       crWe_s;
    logic [5:0] cbAddr_s;
    logic [5:0] crAddr_s;
    logic [8:0] cbVal_s;
    logic [8:0] crVal_s;

    assign gray_s      = (bus.JpegComp == GRAY);
    assign full_s      = (level_r == 2'd3);
    assign outEnable_s = (level_r != 2'd0);
    assign lastColor_s = gray_s ? Y3 : CR;
    assign pixEn_s     = bus.DataInEnable & ~full_s & ~bus.DataInit;
    assign chromaEn_s  = pixEn_s & ~gray_s;
    assign writeNext_s = pixEn_s & (bus.DataInAddress == 8'd255);
    assign readNext_s  = bus.DataOutRead & outEnable_s & ~bus.DataInit &
                         (bus.DataOutAddress == 6'd63) & (bus.DataOutColor == lastColor_s);
    // Quadrant bits first so Y blocks 0..3 land as TL, TR, BL, BR
    assign yAddr_s     = {writeBank_r, bus.DataInAddress[7], bus.DataInAddress[3],
                          bus.DataInAddress[6:4], bus.DataInAddress[2:0]};

    assign bus.DataInFull    = full_s;
    assign bus.DataOutEnable = outEnable_s;
    assign bus.DataOut       = dataOut_r;

    aq_cjpeg_chroma_dec cbDec (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.DataInit),
        .en    (chromaEn_s),
        .pixel (bus.DataInCb),
        .col   (bus.DataInAddress[3:0]),
        .row   (bus.DataInAddress[7:4]),
        .we    (cbWe_s),
        .addr  (cbAddr_s),
        .value (cbVal_s)
    );

    aq_cjpeg_chroma_dec crDec (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.DataInit),
        .en    (chromaEn_s),
        .pixel (bus.DataInCr),
        .col   (bus.DataInAddress[3:0]),
        .row   (bus.DataInAddress[7:4]),
        .we    (crWe_s),
        .addr  (crAddr_s),
        .value (crVal_s)
    );

    // Bank pointers and fill level; reset and flush override both strobes
    always_ff @(posedge clk) begin
        if (!rst || bus.DataInit) begin
            writeBank_r <= 2'd0;
            readBank_r  <= 2'd0;
            level_r     <= 2'd0;
        end else begin
            if (writeNext_s) begin
                writeBank_r <= writeBank_r + 2'd1;
            end
            if (readNext_s) begin
                readBank_r <= readBank_r + 2'd1;
            end
            case ({writeNext_s, readNext_s})
                2'b10:   level_r <= level_r + 2'd1;
                2'b01:   level_r <= level_r - 2'd1;
                default: level_r <= level_r;
            endcase
        end
    end

    // Sample storage; contents survive reset
    always_ff @(posedge clk) begin
        if (pixEn_s) begin
            yMem_r[yAddr_s] <= levelShift(bus.DataInY);
        end
        if (cbWe_s) begin
            cbMem_r[{writeBank_r, cbAddr_s}] <= cbVal_s;
        end
        if (crWe_s) begin
            crMem_r[{writeBank_r, crAddr_s}] <= crVal_s;
        end
    end

    // Read mux for the requested block of the current read bank
    always_comb begin
        readData_s = dataOut_r;
        case (bus.DataOutColor)
            Y0, Y1, Y2, Y3: readData_s = yMem_r[{readBank_r, bus.DataOutColor[1:0], bus.DataOutAddress}];
            CB:             readData_s = cbMem_r[{readBank_r, bus.DataOutAddress}];
            CR:             readData_s = crMem_r[{readBank_r, bus.DataOutAddress}];
            default:        readData_s = dataOut_r;
        endcase
    end

    // Output sample register; a flush leaves the last sample in place
    always_ff @(posedge clk) begin
        if (!rst) begin
            dataOut_r <= 9'd0;
        end else if (bus.DataOutRead && !bus.DataInit) begin
            dataOut_r <= readData_s;
        end
    end

endmodule

// File: tb/tb_aq_cjpeg_ycbcr_mem.sv
// Directed-sequence bench with random pixels, checked against a frame-level model
// of the 4-bank MCU FIFO (raw pixels per bank, samples derived on read).
module tb_aq_cjpeg_ycbcr_mem;
    import aq_cjpeg_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    aq_cjpeg_ycbcr_mem_if bus();

    aq_cjpeg_ycbcr_mem dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    int pixY [256];
    int pixCb[256];
    int pixCr[256];
    int mY [4][256];
    int mCb[4][256];
    int mCr[4][256];
    int mWr = 0;
    int mRd = 0;
    int mLevel = 0;
    int curComp = 3;
    logic [8:0] lastOut = 9'd0;

    function automatic logic [8:0] lvl(input int v);
        logic [8:0] r;
        r = 9'(v - 128);
        return r;
    endfunction

    function automatic int chromaOf(input int b, input bit isCr, input int a);
        int r2, c2, p00, p01, p10, p11;
        r2 = (a / 8) * 2;
        c2 = (a % 8) * 2;
        p00 = isCr ? mCr[b][r2*16 + c2]       : mCb[b][r2*16 + c2];
        p01 = isCr ? mCr[b][r2*16 + c2 + 1]   : mCb[b][r2*16 + c2 + 1];
        p10 = isCr ? mCr[b][r2*16 + 16 + c2]  : mCb[b][r2*16 + 16 + c2];
        p11 = isCr ? mCr[b][r2*16 + 17 + c2]  : mCb[b][r2*16 + 17 + c2];
`ifdef AQ_CJPEG_CHROMA_AVG_EN
        return (p00 + p01 + p10 + p11 + 2) / 4;
`else
        if (p01 + p10 + p11 < 0) return 0;
        return p00;
`endif
    endfunction

    function automatic logic [8:0] expSample(input int b, input int color, input int a);
        int row, col;
        if (color < 4) begin
            row = (color / 2) * 8 + a / 8;
            col = (color % 2) * 8 + a % 8;
            return lvl(mY[b][row*16 + col]);
        end
        return lvl(chromaOf(b, color == 5, a));
    endfunction

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    task automatic checkFlags(input string tag);
        check({tag, "_full"},   {8'd0, bus.DataInFull},    {8'd0, (mLevel == 3)});
        check({tag, "_enable"}, {8'd0, bus.DataOutEnable}, {8'd0, (mLevel != 0)});
    endtask

    task automatic genRandom();
        for (int i = 0; i < 256; i++) begin
            pixY[i]  = int'($urandom_range(0, 255));
            pixCb[i] = int'($urandom_range(0, 255));
            pixCr[i] = int'($urandom_range(0, 255));
        end
    endtask

    // Drives one pixel at the falling edge; the model stores it only if a bank is free
    task automatic putPixel(input int i);
        @(negedge clk);
        bus.DataInEnable  = 1'b1;
        bus.DataInAddress = 8'(i);
        bus.DataInY       = 8'(pixY[i]);
        bus.DataInCb      = 8'(pixCb[i]);
        bus.DataInCr      = 8'(pixCr[i]);
        if (mLevel < 3) begin
            mY[mWr][i] = pixY[i];
            if (curComp != 1) begin
                mCb[mWr][i] = pixCb[i];
                mCr[mWr][i] = pixCr[i];
            end
            if (i == 255) begin
                mWr    = (mWr + 1) % 4;
                mLevel = mLevel + 1;
            end
        end
    endtask

    task automatic stopIn();
        @(negedge clk);
        bus.DataInEnable = 1'b0;
    endtask

    task automatic sendMcu();
        for (int i = 0; i < 256; i++) putPixel(i);
        stopIn();
    endtask

    task automatic readAt(input int color, input int a, input string tag);
        logic [8:0] exp;
        @(negedge clk);
        exp = expSample(mRd, color, a);
        bus.DataOutRead    = 1'b1;
        bus.DataOutColor   = 3'(color);
        bus.DataOutAddress = 6'(a);
        @(posedge clk);
        #1;
        bus.DataOutRead = 1'b0;
        if (mLevel > 0 && a == 63 && color == (curComp == 1 ? 3 : 5)) begin
            mRd    = (mRd + 1) % 4;
            mLevel = mLevel - 1;
        end
        lastOut = exp;
        check(tag, bus.DataOut, exp);
    endtask

    task automatic readMcu(input string tag);
        int n;
        n = (curComp == 1) ? 4 : 6;
        for (int c = 0; c < n; c++) begin
            for (int a = 0; a < 64; a++) readAt(c, a, tag);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] exp;
        bus.DataInit       = 1'b0;
        bus.JpegComp       = 3'd3;
        bus.DataInEnable   = 1'b0;
        bus.DataInAddress  = 8'd0;
        bus.DataInY        = 8'd0;
        bus.DataInCb       = 8'd0;
        bus.DataInCr       = 8'd0;
        bus.DataOutRead    = 1'b0;
        bus.DataOutColor   = 3'd0;
        bus.DataOutAddress = 6'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkFlags("reset");
        check("reset_dataout", bus.DataOut, 9'd0);

        // Gradient fill
        for (int i = 0; i < 256; i++) begin
            pixY[i] = i; pixCb[i] = 64; pixCr[i] = 64;
        end
        sendMcu();
        checkFlags("grad_level1");
        readAt(1, 0, "grad_y_model");
        check("grad_y_const", bus.DataOut, 9'h188);
        readAt(4, 9, "grad_cb_model");
        check("grad_cb_const", bus.DataOut, 9'h1C0);
        @(negedge clk);
        bus.DataOutColor = 3'd0; bus.DataOutAddress = 6'd5;
        @(posedge clk); #1;
        check("hold_dataout", bus.DataOut, lastOut);
        readMcu("grad_mcu");
        checkFlags("grad_drained");

        // Chroma decimation on a known 2x2 cell
        genRandom();
        pixCb[0] = 10; pixCb[1] = 11; pixCb[16] = 12; pixCb[17] = 13;
        sendMcu();
        readAt(4, 0, "avg_model");
`ifdef AQ_CJPEG_CHROMA_AVG_EN
        check("avg_const", bus.DataOut, 9'h18C);
`else
        check("avg_const", bus.DataOut, 9'h18A);
`endif
        readMcu("avg_mcu");

        // Back-pressure
        for (int k = 0; k < 3; k++) begin
            genRandom();
            sendMcu();
        end
        checkFlags("bp_full");
        genRandom();
        sendMcu();
        checkFlags("bp_ignored");
        readMcu("bp_mcu0");
        checkFlags("bp_level2");
        readMcu("bp_mcu1");
        readMcu("bp_mcu2");
        checkFlags("bp_empty");

        // Simultaneous WriteNext and ReadNext at Level 1
        genRandom();
        sendMcu();
        genRandom();
        for (int i = 0; i < 255; i++) putPixel(i);
        stopIn();
        for (int c = 0; c < 6; c++) begin
            for (int a = 0; a < 64; a++) begin
                if (!(c == 5 && a == 63)) readAt(c, a, "sim_mcuA");
            end
        end
        exp = expSample(mRd, 5, 63);
        putPixel(255);
        bus.DataOutRead = 1'b1; bus.DataOutColor = 3'd5; bus.DataOutAddress = 6'd63;
        @(posedge clk); #1;
        bus.DataOutRead = 1'b0;
        mRd = (mRd + 1) % 4;
        mLevel = mLevel - 1;
        lastOut = exp;
        check("sim_last_sample", bus.DataOut, exp);
        stopIn();
        checkFlags("sim_level1");
        readMcu("sim_mcuB");
        checkFlags("sim_empty");

        // Grayscale MCU leaves chroma of its bank untouched
        curComp = 1;
        bus.JpegComp = 3'd1;
        genRandom();
        sendMcu();
        checkFlags("gray_level1");
        for (int k = 0; k < 4; k++) begin
            readAt(4, int'($urandom_range(0, 63)), "gray_cb_kept");
            readAt(5, int'($urandom_range(0, 63)), "gray_cr_kept");
        end
        readMcu("gray_mcu");
        checkFlags("gray_empty");
        curComp = 3;
        bus.JpegComp = 3'd3;

        // Flush in the middle of the second MCU
        genRandom();
        sendMcu();
        genRandom();
        for (int i = 0; i < 100; i++) putPixel(i);
        putPixel(100);
        bus.DataInit = 1'b1;
        @(negedge clk);
        bus.DataInit = 1'b0;
        bus.DataInEnable = 1'b0;
        mWr = 0; mRd = 0; mLevel = 0;
        checkFlags("init_flushed");
        check("init_dataout_held", bus.DataOut, lastOut);
        genRandom();
        sendMcu();
        checkFlags("init_level1");
        readMcu("init_bank0");
        checkFlags("init_empty");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
